// File: rtl/nano_cpu.sv
// nano_cpu: 16-bit multi-cycle load/store CPU sharing one 256x16 memory for code and data
module nano_cpu (
  input  logic        ck,
  input  logic        rst,
  output logic [7:0]  address,
  input  logic [15:0] dataR,
  output logic [15:0] dataW,
  output logic        ce,
  output logic        we
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  state_t state;
  logic [7:0] pc;
  logic [15:0] ir;
  logic [15:0] rf [16];
  logic [3:0] op, t, a, b;
  logic [7:0] addr8, ea;
  logic [15:0] ra, rb, alu;
  logic is_alu, mem_op;
  assign op = ir[15:12];
  assign t = ir[11:8];
  assign a = ir[7:4];
  assign b = ir[3:0];
  assign addr8 = ir[11:4];
  assign ea = addr8 + rf[0][7:0];
  assign ra = rf[a];
  assign rb = rf[b];
  assign is_alu = op >= 4'h4 && op <= 4'hA;
  assign mem_op = op == 4'h0 || op == 4'h2;
  always_comb begin
    alu = op == 4'h4 ? ra ^ rb :
          op == 4'h5 ? ra - rb :
          op == 4'h6 ? ra + rb :
          op == 4'h7 ? {15'd0, ra < rb} :
          op == 4'h8 ? rb + 16'd1 :
          op == 4'h9 ? ra & rb : ra | rb;
    ce = !rst && (state == FETCH || (state == EXEC && mem_op));
    we = !rst && state == EXEC && op == 4'h2;
    address = rst ? 8'd0 : (state == EXEC && mem_op) ? ea : pc;
    dataW = rst ? 16'd0 : rb;
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state <= FETCH;
      pc <= 8'd0;
      ir <= 16'd0;
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          ir <= dataR;
          pc <= pc + 8'd1;
          state <= DECODE;
        end
        DECODE: state <= EXEC;
        EXEC: begin
          state <= op == 4'hF ? HALT : FETCH;
          if (op == 4'h0) rf[b] <= dataR;
          if (is_alu) rf[t] <= alu;
          if (op == 4'h3 && rb != 16'd0) pc <= addr8;
        end
        HALT: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_nano_cpu.sv
// tb_nano_cpu: instruction-level reference model checked against the bus every cycle, plus literal memory checks
module tb_nano_cpu;
  logic ck = 0, rst = 1, load = 0;
  logic [7:0] address;
  logic [15:0] dataR, dataW;
  logic ce, we;
  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] m_r [16];
  logic [15:0] m_mem [256];
  logic [7:0] m_pc;
  logic [15:0] m_ir;
  int m_ph;
  int vec = 0, errs = 0, we_cnt = 0, since = 0, last_ce = 0;
  logic [7:0] we_addr = 0, first_addr = 8'hFF;
  logic first_ce = 0, first_we = 1;
  nano_cpu dut (.ck(ck), .rst(rst), .address(address), .dataR(dataR), .dataW(dataW), .ce(ce), .we(we));
  always #5 ck = ~ck;
  assign dataR = mem[address];
  always @(posedge ck) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (we) mem[address] <= dataW;
  end
  task automatic check();
    logic [3:0] op;
    logic [7:0] ea, e_a;
    logic e_ce, e_we, chk_a;
    logic [15:0] e_d;
    op = m_ir[15:12];
    ea = m_ir[11:4] + m_r[0][7:0];
    chk_a = 1;
    if (rst) begin
      e_ce = 0; e_we = 0; e_a = 0; e_d = 0;
    end else begin
      e_d = m_r[m_ir[3:0]];
      e_a = m_pc;
      e_ce = m_ph == 0;
      e_we = 0;
      if (m_ph == 2) begin
        if (op == 4'h0 || op == 4'h2) begin
          e_ce = 1; e_we = op == 4'h2; e_a = ea;
        end else chk_a = 0;
      end
    end
    vec++;
    if (ce !== e_ce || we !== e_we || (chk_a && address !== e_a) || dataW !== e_d) begin
      errs++;
      $display("FAIL bus @%0t: ce=%b we=%b addr=%h dataW=%h, required ce=%b we=%b addr=%h dataW=%h",
               $time, ce, we, address, dataW, e_ce, e_we, e_a, e_d);
    end
    if (!rst) begin
      if (since == 0) begin
        first_addr = address; first_ce = ce; first_we = we;
      end
      since++;
      if (ce) last_ce = since;
      if (we) begin
        we_cnt++; we_addr = address;
      end
    end
  endtask
  task automatic model_step();
    logic [3:0] op, t, a, b;
    logic [7:0] ea;
    if (load) for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    if (rst) begin
      m_pc = 0; m_ir = 0; m_ph = 0; since = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
    end else if (m_ph == 0) begin
      m_ir = m_mem[m_pc];
      m_pc = m_pc + 8'd1;
      m_ph = 1;
    end else if (m_ph == 1) m_ph = 2;
    else if (m_ph == 2) begin
      op = m_ir[15:12]; t = m_ir[11:8]; a = m_ir[7:4]; b = m_ir[3:0];
      ea = m_ir[11:4] + m_r[0][7:0];
      m_ph = 0;
      case (op)
        4'h0: m_r[b] = m_mem[ea];
        4'h2: m_mem[ea] = m_r[b];
        4'h3: if (m_r[b] != 0) m_pc = m_ir[11:4];
        4'h4: m_r[t] = m_r[a] ^ m_r[b];
        4'h5: m_r[t] = m_r[a] - m_r[b];
        4'h6: m_r[t] = m_r[a] + m_r[b];
        4'h7: m_r[t] = (m_r[a] < m_r[b]) ? 16'd1 : 16'd0;
        4'h8: m_r[t] = m_r[b] + 16'd1;
        4'h9: m_r[t] = m_r[a] & m_r[b];
        4'hA: m_r[t] = m_r[a] | m_r[b];
        4'hF: m_ph = 3;
        default: ;
      endcase
    end
  endtask
  task automatic cyc();
    @(negedge ck);
    check();
    @(posedge ck);
    model_step();
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 256; i++) img[i] = 16'd0;
  endtask
  task automatic start();
    rst = 1; load = 1;
    cyc();
    load = 0;
    cyc();
    rst = 0;
    we_cnt = 0;
  endtask
  initial begin
    clr();
    img[0] = 16'h8101; img[1] = 16'h4111; img[2] = 16'h20A1; img[3] = 16'hF000; img[10] = 16'hFFFF;
    start();
    run(20);
    lit("first_addr", {8'd0, first_addr}, 16'h0000);
    lit("first_ce", {15'd0, first_ce}, 16'd1);
    lit("first_we", {15'd0, first_we}, 16'd0);
    lit("xor_self", mem[10], 16'h0000);
    clr();
    img[0] = 16'h01E3; img[1] = 16'h20F3; img[2] = 16'hF000; img[30] = 16'h000A;
    start();
    run(30);
    lit("roundtrip", mem[15], 16'h000A);
    lit("we_count", we_cnt[15:0], 16'd1);
    lit("we_addr", {8'd0, we_addr}, 16'h000F);
    clr();
    img[0] = 16'h0283; img[1] = 16'h8000; img[2] = 16'h8000; img[3] = 16'h20F3; img[4] = 16'hF000;
    img[40] = 16'h1234;
    start();
    run(30);
    lit("indexed", mem[17], 16'h1234);
    lit("unindexed", mem[15], 16'h0000);
    clr();
    img[0] = 16'h0321; img[1] = 16'h0332; img[2] = 16'h6312; img[3] = 16'h5412; img[4] = 16'h5521;
    img[5] = 16'h7621; img[6] = 16'h7712; img[7] = 16'h4812; img[8] = 16'h9912; img[9] = 16'hAA12;
    img[10] = 16'h23C3; img[11] = 16'h23D4; img[12] = 16'h23E5; img[13] = 16'h23F6; img[14] = 16'h2407;
    img[15] = 16'h2418; img[16] = 16'h2429; img[17] = 16'h243A; img[18] = 16'hF000;
    img[50] = 16'd5; img[51] = 16'd3;
    start();
    run(70);
    lit("add", mem[60], 16'h0008);
    lit("sub", mem[61], 16'h0002);
    lit("sub_wrap", mem[62], 16'hFFFE);
    lit("less_t", mem[63], 16'h0001);
    lit("less_f", mem[64], 16'h0000);
    lit("xor", mem[65], 16'h0006);
    lit("and", mem[66], 16'h0001);
    lit("or", mem[67], 16'h0007);
    for (int k = 0; k < 2; k++) begin
      clr();
      img[0] = 16'h0282; img[1] = 16'h30A2; img[2] = 16'h2650; img[3] = 16'hF000;
      img[10] = 16'h8101; img[11] = 16'h2641; img[12] = 16'hF000;
      img[40] = k == 0 ? 16'd1 : 16'd0; img[100] = 16'h5555; img[101] = 16'hBEEF;
      start();
      run(30);
      lit(k == 0 ? "br_taken_target" : "br_nt_target", mem[100], k == 0 ? 16'h0001 : 16'h5555);
      lit(k == 0 ? "br_taken_skip" : "br_nt_fall", mem[101], k == 0 ? 16'hBEEF : 16'h0000);
    end
    clr();
    img[0] = 16'h01E1; img[1] = 16'h8202; img[2] = 16'h8303; img[3] = 16'h20F2; img[4] = 16'h8000;
    img[5] = 16'h6223; img[6] = 16'h20F3; img[7] = 16'h8000; img[8] = 16'h6332; img[9] = 16'h7601;
    img[10] = 16'h3036; img[11] = 16'hF000; img[30] = 16'd10;
    start();
    run(160);
    begin
      int fib [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      for (int i = 0; i < 10; i++) lit($sformatf("fib[%0d]", i), mem[15 + i], fib[i][15:0]);
    end
    lit("fib_untouched", mem[25], 16'h0000);
    vec++;
    if (last_ce > 150) begin
      errs++;
      $display("FAIL fib_halt: last access at cycle %0d, required within 150", last_ce);
    end
    clr();
    img[0] = 16'h8101; img[1] = 16'h20A1; img[2] = 16'hF000; img[10] = 16'h7777;
    start();
    run(5);
    rst = 1;
    cyc();
    lit("abort_write", mem[10], 16'h7777);
    cyc();
    rst = 0;
    run(20);
    lit("rerun_write", mem[10], 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
